tqv_gpio_irq: RTL
=================

# tqv_gpio_irq

Parametrised GPIO peripheral for the tinyQV peripheral bus. It replaces the fixed 2-bit GPIO output and raw input read with a width-configurable output register that has atomic set/clear/toggle. Inputs are synchronised, and per-pin rising/falling edge interrupt detection drives a level interrupt request. The block sits behind the top-level address decoder, which asserts `sel` for its 32-byte window.

## Interface
Parameters:
- `NUM_IN`, default 8: input pin count, 1..16.
- `NUM_OUT`, default 8: output pin count, 1..32.
- `SYNC_STAGES`, default 2: input synchroniser depth, 2..3.
- `OUT_RESET`, default 0: reset value of the output register, `NUM_OUT` bits.

Ports:
- `clk`  in  1  sole clock; all flops are rising-edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `sel`  in  1  peripheral window selected by the top-level decoder.
- `addr`  in  3  word offset within the window, taken from byte address [4:2].
- `write_n`  in  2  2'b11 means no write; any other value is a write of the full register.
- `read_n`  in  2  2'b11 means no read.
- `data_in`  in  32  write data.
- `data_out`  out  32  read data, combinational.
- `gpio_in`  in  `NUM_IN`  asynchronous input pins.
- `gpio_out`  out  `NUM_OUT`  registered outputs.
- `irq`  out  1  level interrupt, the OR of pending-and-enabled bits.

## Operation
Register map, by word offset:
- 0 OUT: read/write.
- 1 IN: read-only synchronised inputs.
- 2 IRQ_EN: read/write. Bits [`NUM_IN`-1:0] enable rising edge; bits [16+`NUM_IN`-1:16] enable falling edge.
- 3 IRQ_PEND: read, write-1-to-clear. Same bit layout as IRQ_EN.
- 4 OUT_SET: write-only; ORs into OUT.
- 5 OUT_CLR: write-only; ANDs the inverse into OUT.
- 6 OUT_TGL: write-only; XORs into OUT.
- 7: reserved.

Read rules:
- Read data is valid whenever `sel` is high; `read_n` has no side effects.
- Unused upper bits read 0.
- Offset 7 and the write-only offsets 4–6 read 32'hFFFF_FFFF, matching the bus default for unmapped addresses.
- When `sel`=0, `data_out` = 32'hFFFF_FFFF.

Write rules:
- A write takes effect only when `sel`=1 and `write_n`≠2'b11.
- Writes to IN and to offset 7 are ignored.

Edge detection:
- Each input passes through a `SYNC_STAGES`-deep flop chain, followed by one "previous" flop.
- Rising = sync & ~prev; falling = ~sync & prev.
- A detected edge whose enable bit is set sets its pend bit on the next edge of `clk`.
- Pend bits stay set until cleared by a W1C write.

Simultaneous events:
- W1C clear and a new edge on the same bit in the same cycle: set wins, and the bit stays 1.
- Disabling an enable bit does not clear its pend bit. `irq` masks with the current enable, so `irq` = |(pend & en).

Reset:
- OUT = `OUT_RESET`; IRQ_EN = 0; IRQ_PEND = 0; synchroniser and prev flops = 0; `irq` = 0.
- Inputs high at reset release produce a rising-edge detection after synchronisation. Because all enables are 0, nothing pends.
- Reset asserted mid-operation clears all state immediately (asynchronously).

## Timing
- Register writes are visible on `gpio_out` and in readback one cycle after the write cycle's clock edge.
- Input change to IN readback: an edge sampled on clock k appears in IN after clock k+`SYNC_STAGES`-1.
- The pend bit sets at clock k+`SYNC_STAGES`, and `irq` rises in the same cycle.
- `irq` is combinational from flops only; it has no path from bus inputs.
- No wait states: the top level holds `data_ready` at 1.

## Structure
- Package `tqv_gpio_pkg`: localparams for register word offsets (`GPIO_OUT`, `GPIO_IN`, `GPIO_IRQ_EN`, `GPIO_IRQ_PEND`, `GPIO_OUT_SET`, `GPIO_OUT_CLR`, `GPIO_OUT_TGL`), `FALL_SHIFT`=16, and the unmapped read value 32'hFFFF_FFFF.
- Sub-module `tqv_sync_edge`, parameter `STAGES`: a single-bit synchroniser plus prev flop.
  - Outputs: `sync`, `rise`, `fall`.
  - The top instantiates it `NUM_IN` times in a generate loop.

## Test plan
1. Reset with `OUT_RESET`=8'hA5 → `gpio_out`=8'hA5, `irq`=0, read offset 3 = 0, read offset 7 = FFFF_FFFF.
2. Write OUT=8'h0F, SET 8'h30, CLR 8'h01, TGL 8'hFF → after each write `gpio_out` = 8'h0F, 8'h3F, 8'h3E, 8'hC1.
3. IRQ_EN=32'h0000_0004; drive `gpio_in[2]` 0→1 → pend bit 2 and `irq` set exactly `SYNC_STAGES`+1 edges after the change; drive 1→0 → no falling pend.
4. IRQ_EN bit 18; `gpio_in[2]` 1→0 → pend bit 18 set; write IRQ_PEND=32'h0004_0000 → bit clears and `irq`=0 the next cycle.
5. Time a W1C of bit 2 to coincide with a new rising-edge detection on pin 2 → pend bit 2 remains 1 and `irq` stays high.
6. Assert `rstn` low mid-pulse with pend set → `irq`, pend and OUT reset immediately, without waiting for a clock; a write with `sel`=0 changes nothing.

Source files
------------

// File: rtl/tqv_gpio_pkg.sv
// Shared constants for the tinyQV GPIO peripheral: register word offsets and bus defaults.
package tqv_gpio_pkg;

  localparam logic [2:0] GPIO_OUT      = 3'd0;
  localparam logic [2:0] GPIO_IN       = 3'd1;
  localparam logic [2:0] GPIO_IRQ_EN   = 3'd2;
  localparam logic [2:0] GPIO_IRQ_PEND = 3'd3;
  localparam logic [2:0] GPIO_OUT_SET  = 3'd4;
  localparam logic [2:0] GPIO_OUT_CLR  = 3'd5;
  localparam logic [2:0] GPIO_OUT_TGL  = 3'd6;

  // Falling-edge enable/pend bits live in the upper half-word.
  localparam int FALL_SHIFT = 16;

  localparam logic [31:0] UNMAPPED_RD = 32'hFFFF_FFFF;

endpackage

// File: rtl/tqv_sync_edge.sv
// Single-bit input synchroniser followed by a "previous" flop for edge detection.
module tqv_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_d,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] r_chain;
  logic              r_prev;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_chain <= '0;
      r_prev  <= 1'b0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
      r_prev  <= r_chain[STAGES-1];
    end
  end

  assign sync = r_chain[STAGES-1];
  assign rise = sync & ~r_prev;
  assign fall = ~sync & r_prev;

endmodule

// File: rtl/tqv_gpio_irq.sv
// GPIO peripheral: output register with atomic set/clear/toggle, synchronised inputs,
// per-pin rising/falling edge interrupts with W1C pending bits and a level irq.
module tqv_gpio_irq
  import tqv_gpio_pkg::*;
#(
  parameter int                   NUM_IN      = 8,
  parameter int                   NUM_OUT     = 8,
  parameter int                   SYNC_STAGES = 2,
  parameter logic [NUM_OUT-1:0]   OUT_RESET   = '0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               sel,
  input  logic [2:0]         addr,
  input  logic [1:0]         write_n,
  input  logic [1:0]         read_n,
  input  logic [31:0]        data_in,
  output logic [31:0]        data_out,
  input  logic [NUM_IN-1:0]  gpio_in,
  output logic [NUM_OUT-1:0] gpio_out,
  output logic               irq
);

  logic [NUM_OUT-1:0] r_out;
  logic [NUM_IN-1:0]  r_en_rise, r_en_fall;
  logic [NUM_IN-1:0]  r_pend_rise, r_pend_fall;

  logic [NUM_IN-1:0]  w_sync, w_rise, w_fall;
  logic [NUM_IN-1:0]  w_clr_rise, w_clr_fall;
  logic               w_wr;
  logic [31:0]        w_rd;
  logic               w_unused;

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_sync
    tqv_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rstn (rstn),
      .i_d  (gpio_in[gi]),
      .sync (w_sync[gi]),
      .rise (w_rise[gi]),
      .fall (w_fall[gi])
    );
  end

  assign w_wr       = sel && (write_n != 2'b11);
  assign w_clr_rise = (w_wr && addr == GPIO_IRQ_PEND) ? data_in[NUM_IN-1:0] : '0;
  assign w_clr_fall = (w_wr && addr == GPIO_IRQ_PEND) ? data_in[FALL_SHIFT +: NUM_IN] : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out <= OUT_RESET;
    end else if (w_wr) begin
      case (addr)
        GPIO_OUT:     r_out <= data_in[NUM_OUT-1:0];
        GPIO_OUT_SET: r_out <= r_out | data_in[NUM_OUT-1:0];
        GPIO_OUT_CLR: r_out <= r_out & ~data_in[NUM_OUT-1:0];
        GPIO_OUT_TGL: r_out <= r_out ^ data_in[NUM_OUT-1:0];
        default:      r_out <= r_out;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_en_rise <= '0;
      r_en_fall <= '0;
    end else if (w_wr && addr == GPIO_IRQ_EN) begin
      r_en_rise <= data_in[NUM_IN-1:0];
      r_en_fall <= data_in[FALL_SHIFT +: NUM_IN];
    end
  end

  // A new enabled edge in the same cycle as a W1C keeps the bit set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend_rise <= '0;
      r_pend_fall <= '0;
    end else begin
      r_pend_rise <= (r_pend_rise & ~w_clr_rise) | (w_rise & r_en_rise);
      r_pend_fall <= (r_pend_fall & ~w_clr_fall) | (w_fall & r_en_fall);
    end
  end

  always_comb begin
    w_rd = '0;
    if (!sel) begin
      w_rd = UNMAPPED_RD;
    end else begin
      case (addr)
        GPIO_OUT: w_rd[NUM_OUT-1:0] = r_out;
        GPIO_IN:  w_rd[NUM_IN-1:0]  = w_sync;
        GPIO_IRQ_EN: begin
          w_rd[NUM_IN-1:0]           = r_en_rise;
          w_rd[FALL_SHIFT +: NUM_IN] = r_en_fall;
        end
        GPIO_IRQ_PEND: begin
          w_rd[NUM_IN-1:0]           = r_pend_rise;
          w_rd[FALL_SHIFT +: NUM_IN] = r_pend_fall;
        end
        default: w_rd = UNMAPPED_RD;
      endcase
    end
  end

  assign data_out = w_rd;
  assign gpio_out = r_out;
  assign irq      = (|(r_pend_rise & r_en_rise)) | (|(r_pend_fall & r_en_fall));

  // Reads have no side effects, and not every data bit maps to a register.
  assign w_unused = &{1'b0, read_n, data_in};

endmodule
